// File: rtl/dmem_arb_pkg.sv
// Shared types and RV32I load/store width codes for the data-memory arbiter
// and the memory transmitter/receiver.
package dmem_arb_pkg;

  typedef enum logic {ST_IDLE, ST_RSP} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // One port's request payload as seen by the memory unit.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
  } mem_req_t;

  function automatic mem_req_t pack_req(input logic        we,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [2:0]  func3);
    mem_req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    r.func3 = func3;
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory unit: CPU has fixed
// priority, a starvation counter guarantees the debug port eventually wins.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_func3,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,

  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_func3,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,

  output logic        mem_en_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_store_data,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_load_data
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  arb_state_t      state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      func3_q, func3_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  mem_req_t cpu_r, dbg_r, win_r;
  logic     dbg_win, cpu_win;

  assign cpu_r = pack_req(cpu_we, cpu_addr, cpu_wdata, cpu_func3);
  assign dbg_r = pack_req(dbg_we, dbg_addr, dbg_wdata, dbg_func3);

  always_comb begin
    state_d      = ST_IDLE;
    owner_d      = owner_q;
    addr_d       = addr_q;
    func3_d      = func3_q;
    starve_cnt_d = starve_cnt_q;

    cpu_gnt        = 1'b0;
    dbg_gnt        = 1'b0;
    cpu_rvalid     = 1'b0;
    dbg_rvalid     = 1'b0;
    cpu_rdata      = '0;
    dbg_rdata      = '0;
    mem_en_write   = 1'b0;
    mem_address    = '0;
    mem_store_data = '0;
    mem_func3      = '0;
    dbg_win        = 1'b0;
    cpu_win        = 1'b0;
    win_r          = '0;

    // Gating on rst keeps grants low while a held request sits on an idle port.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          dbg_win = dbg_req & (~cpu_req | (starve_cnt_q == CntMax));
          cpu_win = cpu_req & ~dbg_win;
          win_r   = dbg_win ? dbg_r : cpu_r;

          if (dbg_win || cpu_win) begin
            cpu_gnt        = cpu_win;
            dbg_gnt        = dbg_win;
            mem_en_write   = win_r.we;
            mem_address    = win_r.addr;
            mem_store_data = win_r.wdata;
            mem_func3      = win_r.func3;
            if (!win_r.we) begin
              state_d = ST_RSP;
              owner_d = dbg_win ? OWN_DBG : OWN_CPU;
              addr_d  = win_r.addr;
              func3_d = win_r.func3;
            end
          end

          if (cpu_win && dbg_req) begin
            if (starve_cnt_q != CntMax) begin
              starve_cnt_d = starve_cnt_q + CntW'(1);
            end
          end else begin
            starve_cnt_d = '0;
          end
        end

        ST_RSP: begin
          mem_address = addr_q;
          mem_func3   = func3_q;
          if (owner_q == OWN_DBG) begin
            dbg_rvalid = 1'b1;
            dbg_rdata  = mem_load_data;
          end else begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = mem_load_data;
          end
          state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      addr_q       <= '0;
      func3_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      func3_q      <= func3_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data memory unit between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- Sequences each access:
  - Writes occupy the memory for one cycle.
  - Reads occupy it for two: address cycle, then response cycle with address/Func3 held for the load receiver.
- CPU has fixed priority, bounded by a starvation limit so DBG always progresses.
- Sits between the MEM stage / debug module and the data memory unit; drives the MEM-stage stall.

## Interface
- `STARVE_LIMIT`, 4: max consecutive CPU grants while DBG waits; must be ≥1.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `cpu_req` / `dbg_req`  in  1  access request; held with its payload stable until granted.
- `cpu_we` / `dbg_we`  in  1  1 = store, 0 = load.
- `cpu_addr` / `dbg_addr`  in  32  byte address.
- `cpu_wdata` / `dbg_wdata`  in  32  store data (unaligned as from register file).
- `cpu_func3` / `dbg_func3`  in  3  RV32I load/store width code.
- `cpu_gnt` / `dbg_gnt`  out  1  access accepted this cycle (combinational).
- `cpu_rvalid` / `dbg_rvalid`  out  1  load data valid this cycle.
- `cpu_rdata` / `dbg_rdata`  out  32  formatted load data; 0 when rvalid low.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `mem_en_write`  out  1  write enable to memory unit.
- `mem_address`  out  32  address to memory unit.
- `mem_store_data`  out  32  store data to memory unit.
- `mem_func3`  out  3  Func3 to memory unit.
- `mem_load_data`  in  32  formatted load data from memory unit (synchronous read, valid cycle after address).

## Operation
- **FSM states:** `ST_IDLE`, `ST_RSP`. Reset → `ST_IDLE`.
- **`ST_IDLE` arbitration:**
  - DBG wins if `dbg_req & (~cpu_req | starve_cnt == STARVE_LIMIT)`; otherwise CPU wins if `cpu_req`.
  - The winner's gnt is 1 and its payload drives the mem_* outputs combinationally.
  - `mem_en_write = winner_we`.
- **Granted store:** completes in that cycle; FSM stays `ST_IDLE`.
- **Granted load:** registers owner, address and func3; next state `ST_RSP`.
- **`ST_RSP`:**
  - No grants.
  - `mem_en_write = 0`; `mem_address`/`mem_func3` = registered copies; `mem_store_data = 0`.
  - Owner's rvalid = 1 and owner's rdata = `mem_load_data`.
  - Always returns to `ST_IDLE`.
- **Idle mem_* outputs:** with no request in `ST_IDLE`, all mem_* outputs are 0.
- **`starve_cnt`**, width `$clog2(STARVE_LIMIT+1)`, in `ST_IDLE` only:
  - +1 when CPU granted while `dbg_req` = 1.
  - Cleared on DBG grant, or when `dbg_req` = 0.
  - Saturates at `STARVE_LIMIT`; held in `ST_RSP`.
- **Addresses:** passed unmodified, 32 bits. Truncation and misalignment handling belong to the memory unit.

## Timing
- Store: 1 cycle from req to completion; gnt in the request cycle.
- Load: gnt in cycle N, rvalid/rdata in cycle N+1; earliest next grant is N+2.
- Requests arriving during `ST_RSP` see gnt = 0 (CPU stalls) and are arbitrated in the following `ST_IDLE` cycle.
- Both ports request in the same cycle: one grant only, per the priority rule; the loser stays stalled.
- **Reset values** (outputs are combinational from state, so they take these values immediately on `rst` assertion, without waiting for a clock edge):
  - all gnt, rvalid, `mem_en_write` = 0; rdata = 0.
  - `starve_cnt` = 0; owner register = CPU; held address/func3 = 0.
- **Reset mid-read:** the pending response is discarded; nothing is written.

## Structure
- **Package `dmem_arb_pkg`:**
  - `typedef enum logic {ST_IDLE, ST_RSP} arb_state_t`.
  - `typedef enum logic {OWN_CPU, OWN_DBG} owner_t`.
  - func3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, `F3_SB`, `F3_SH`, `F3_SW`, shared with the memory transmitter/receiver.
- **Flat module.** The starvation counter is small enough to stay inline; no sub-module.
- **Memory unit is not instantiated here.** The MEM-stage top wires `dmem_arbiter` to `data_memory_unit`.

## Test plan
- **CPU store alone:** `cpu_req`=1, we=1, addr=0x8, wdata=0xDEADBEEF, func3=010 → same cycle `cpu_gnt`=1, `mem_en_write`=1, `mem_address`=0x8; next cycle FSM `ST_IDLE`, `cpu_stall`=0.
- **CPU load word:** then CPU lw 0x8 → `cpu_gnt`=1 in cycle N; cycle N+1 `cpu_rvalid`=1, `cpu_rdata`=0xDEADBEEF, `mem_address`=0x8 held, `mem_en_write`=0.
- **DBG byte load:** DBG lbu 0xB (func3=100) → `dbg_rvalid` next cycle, `dbg_rdata`=0x000000DE, `cpu_rdata`=0.
- **Starvation bound:** STARVE_LIMIT=4, both ports issue back-to-back stores continuously → CPU granted cycles 0–3, DBG granted cycle 4, CPU cycles 5–8, DBG cycle 9; `cpu_stall`=1 exactly in cycles 4 and 9.
- **Load blocks port:** CPU load granted at N; DBG req at N+1 → `dbg_gnt`=0 at N+1, `dbg_gnt`=1 at N+2 (CPU idle).
- **Reset mid-read:** `rst` raised during `ST_RSP` → `cpu_rvalid`=0 and all gnt=0 without a clock edge; after release, first request is granted from `ST_IDLE` with `starve_cnt`=0.
